// File: rtl/clk_div_multi_pkg.sv
// Shared defaults and helpers for the multi-channel clock/tick divider.
//   CNT_W_DEF   : default divisor/counter width
//   DEF_DIV_DEF : default divisor loaded into every channel at reset
//   ch_w()      : width of the channel-select field, never below 1
package clk_div_multi_pkg;

  localparam int CNT_W_DEF   = 26;
  localparam int DEF_DIV_DEF = 50_000_000;

  function automatic int ch_w(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/clk_div_multi_chan.sv
// One divider channel: period counter, active divisor, shadow divisor with
// pending flag, and registered square-wave / tick outputs.
// Ports:
//   clk, rst_n : clock, async active-low reset
//   en         : run enable; low holds the counter at 0 and outputs low
//   clr        : phase-align restart (overrides en and wrap)
//   wr, wr_div : accepted divisor write (only issued while pend is low)
//   pend       : a shadow divisor waits for its application point
//   slw_clk    : divided square wave, low floor(D/2) then high ceil(D/2)
//   tick       : one-cycle pulse on the edge that wraps the period
module clk_div_multi_chan import clk_div_multi_pkg::*; #(
  parameter int CNT_W   = CNT_W_DEF,
  parameter int DEF_DIV = DEF_DIV_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             clr,
  input  logic             wr,
  input  logic [CNT_W-1:0] wr_div,
  output logic             pend,
  output logic             slw_clk,
  output logic             tick
);

  logic [CNT_W-1:0] cnt, div, shadow;
  logic [CNT_W-1:0] cnt_nx, div_nx, shadow_nx;
  logic             pend_nx, tick_nx, slw_nx, wrap;

  always_comb begin
    cnt_nx    = '0;
    div_nx    = div;
    shadow_nx = shadow;
    pend_nx   = pend;
    tick_nx   = 1'b0;
    slw_nx    = 1'b0;
    wrap      = (cnt == div - CNT_W'(1));

    if (clr || !en) begin
      // Stopped or restarted: nothing is mid-period, so a pending divisor
      // can take effect right away.
      if (pend) begin
        div_nx  = shadow;
        pend_nx = 1'b0;
      end
    end else begin
      cnt_nx  = wrap ? '0 : cnt + CNT_W'(1);
      tick_nx = wrap;
      if (wrap && pend) begin
        div_nx  = shadow;
        pend_nx = 1'b0;
      end
      // Threshold taken from the divisor governing the period being entered,
      // so a switch to D=1 produces a high level on the very first cycle.
      slw_nx = (cnt_nx >= (div_nx >> 1));
    end

    // A write is only issued while pend is low, so it never collides with
    // an application on the same edge; it waits for the following one.
    if (wr) begin
      shadow_nx = wr_div;
      pend_nx   = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt     <= '0;
      div     <= CNT_W'(DEF_DIV);
      shadow  <= '0;
      pend    <= 1'b0;
      tick    <= 1'b0;
      slw_clk <= 1'b0;
    end else begin
      cnt     <= cnt_nx;
      div     <= div_nx;
      shadow  <= shadow_nx;
      pend    <= pend_nx;
      tick    <= tick_nx;
      slw_clk <= slw_nx;
    end
  end

endmodule

// File: rtl/clk_div_multi.sv
// Multi-channel programmable clock/tick generator. NCH independent channels
// each divide Clk by a runtime divisor, with shadowed glitch-free updates.
// Ports:
//   Clk, Rst_n          : clock, async active-low reset
//   en[NCH]             : per-channel run enable
//   sync_clr            : restart all channels phase-aligned
//   cfg_valid/ch/div    : divisor write request
//   cfg_ready           : target channel has no pending divisor
//   cfg_err             : one-cycle pulse after a rejected write
//   slw_clk[NCH], tick[NCH] : registered channel outputs
module clk_div_multi import clk_div_multi_pkg::*; #(
  parameter  int NCH     = 4,
  parameter  int CNT_W   = CNT_W_DEF,
  parameter  int DEF_DIV = DEF_DIV_DEF,
  localparam int CH_W    = ch_w(NCH)
) (
  input  logic             Clk,
  input  logic             Rst_n,
  input  logic [NCH-1:0]   en,
  input  logic             sync_clr,
  input  logic             cfg_valid,
  input  logic [CH_W-1:0]  cfg_ch,
  input  logic [CNT_W-1:0] cfg_div,
  output logic             cfg_ready,
  output logic             cfg_err,
  output logic [NCH-1:0]   slw_clk,
  output logic [NCH-1:0]   tick
);

  logic [NCH-1:0]       pend, wr;
  logic [2**CH_W-1:0]   pend_pad;
  logic                 ch_bad, div_bad, take;

  assign ch_bad  = (32'(cfg_ch) >= 32'(NCH));
  assign div_bad = (cfg_div == '0);
  // Out-of-range channels read as "ready" so the bad write completes its
  // handshake and is reported through cfg_err instead of stalling.
  assign cfg_ready = ~pend_pad[cfg_ch];
  assign take      = cfg_valid & cfg_ready;

  genvar g;
  generate
    for (g = 0; g < 2**CH_W; g++) begin : g_pad
      if (g < NCH) begin : g_real
        assign pend_pad[g] = pend[g];
      end else begin : g_none
        assign pend_pad[g] = 1'b0;
      end
    end

    for (g = 0; g < NCH; g++) begin : g_ch
      assign wr[g] = take & ~div_bad & (cfg_ch == CH_W'(g));

      clk_div_multi_chan #(
        .CNT_W   (CNT_W),
        .DEF_DIV (DEF_DIV)
      ) u_chan (
        .clk     (Clk),
        .rst_n   (Rst_n),
        .en      (en[g]),
        .clr     (sync_clr),
        .wr      (wr[g]),
        .wr_div  (cfg_div),
        .pend    (pend[g]),
        .slw_clk (slw_clk[g]),
        .tick    (tick[g])
      );
    end
  endgenerate

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) cfg_err <= 1'b0;
    else        cfg_err <= take & (ch_bad | div_bad);
  end

endmodule

// File: tb/tb_clk_div_multi.sv
module tb_clk_div_multi;
  localparam int NCH = 3, CNT_W = 8, DEF_DIV = 4, CH_W = 2;

  logic             Clk, Rst_n, sync_clr, cfg_valid, cfg_ready, cfg_err;
  logic [NCH-1:0]   en, slw_clk, tick;
  logic [CH_W-1:0]  cfg_ch;
  logic [CNT_W-1:0] cfg_div;

  int n_chk = 0, n_pass = 0;

  clk_div_multi #(.NCH(NCH), .CNT_W(CNT_W), .DEF_DIV(DEF_DIV)) dut (
    .Clk(Clk), .Rst_n(Rst_n), .en(en), .sync_clr(sync_clr),
    .cfg_valid(cfg_valid), .cfg_ch(cfg_ch), .cfg_div(cfg_div),
    .cfg_ready(cfg_ready), .cfg_err(cfg_err), .slw_clk(slw_clk), .tick(tick)
  );

  initial begin Clk = 0; forever #5 Clk = ~Clk; end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // Behavioural model: each channel tracks its phase within the period,
  // its period length, and one pending replacement length.
  int  m_d[NCH], m_sh[NCH], m_ph[NCH];
  bit  m_pd[NCH], m_tk[NCH], m_sw[NCH];
  bit  m_err;

  function automatic bit m_ready(input int ch);
    return (ch >= NCH) ? 1'b1 : !m_pd[ch];
  endfunction

  always @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      m_err = 0;
      for (int i = 0; i < NCH; i++) begin
        m_d[i] = DEF_DIV; m_sh[i] = 0; m_ph[i] = 0;
        m_pd[i] = 0; m_tk[i] = 0; m_sw[i] = 0;
      end
    end else begin
      int  ch;
      bit  bad, acc, rdy;
      ch  = int'(cfg_ch);
      rdy = m_ready(ch);
      bad = (cfg_div == 0) || (ch >= NCH);
      m_err = cfg_valid && rdy && bad;
      acc   = cfg_valid && rdy && !bad;
      for (int i = 0; i < NCH; i++) begin
        bit had_pd;
        had_pd = m_pd[i];
        if (sync_clr || !en[i]) begin
          m_ph[i] = 0; m_tk[i] = 0; m_sw[i] = 0;
          if (had_pd) begin m_d[i] = m_sh[i]; m_pd[i] = 0; end
        end else begin
          m_ph[i] = (m_ph[i] + 1) % m_d[i];
          m_tk[i] = (m_ph[i] == 0);
          if (m_tk[i] && had_pd) begin m_d[i] = m_sh[i]; m_pd[i] = 0; end
          m_sw[i] = (m_ph[i] >= m_d[i] / 2);
        end
        if (acc && ch == i) begin m_sh[i] = int'(cfg_div); m_pd[i] = 1; end
      end
    end
  end

  // Cycle-by-cycle comparison against the model.
  always @(negedge Clk) begin
    logic [NCH-1:0] e_tk, e_sw;
    for (int i = 0; i < NCH; i++) begin e_tk[i] = m_tk[i]; e_sw[i] = m_sw[i]; end
    chk("model_tick", 32'(tick), 32'(e_tk));
    chk("model_slw", 32'(slw_clk), 32'(e_sw));
    chk("model_err", 32'(cfg_err), 32'(m_err));
    chk("model_ready", 32'(cfg_ready), 32'(m_ready(int'(cfg_ch))));
  end

  task automatic step(input int n = 1);
    repeat (n) begin @(posedge Clk); #2; end
  endtask

  task automatic write(input int ch, input int d);
    bit ok;
    ok = 0;
    cfg_ch = CH_W'(ch); cfg_div = CNT_W'(d); cfg_valid = 1; #1;
    for (int i = 0; i < 20; i++) begin
      if (cfg_ready) begin ok = 1; break; end
      step(); #1;
    end
    chk("write_ready_timeout", 32'(ok), 32'd1);
    step();
    cfg_valid = 0;
  endtask

  task automatic wait_tick(input int ch, input string name);
    bit seen;
    seen = 0;
    for (int i = 0; i < 12; i++) begin
      step();
      if (tick[ch]) begin seen = 1; break; end
    end
    chk(name, 32'(seen), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    Rst_n = 0; en = '0; sync_clr = 0; cfg_valid = 0; cfg_ch = '0; cfg_div = '0;
    step(2);
    chk("reset_tick", 32'(tick), 32'd0);
    chk("reset_slw", 32'(slw_clk), 32'd0);
    chk("reset_err", 32'(cfg_err), 32'd0);

    // 1: default D=4 on ch0 from reset release
    Rst_n = 1; en = 3'b001;
    for (int k = 1; k <= 12; k++) begin
      step();
      chk("t1_tick", 32'(tick[0]), 32'(k % 4 == 0));
      chk("t1_slw", 32'(slw_clk[0]), 32'(k % 4 >= 2));
    end

    // 2: D=5 written mid-period on ch1; ch2 write still accepted
    en = 3'b111;
    step(2);
    cfg_ch = 2'd1; cfg_div = 8'd5; cfg_valid = 1;
    step();
    cfg_valid = 0; #1;
    chk("t2_ready_ch1_pending", 32'(cfg_ready), 32'd0);
    cfg_ch = 2'd2; cfg_div = 8'd6; cfg_valid = 1; #1;
    chk("t2_ready_ch2", 32'(cfg_ready), 32'd1);
    step();
    cfg_valid = 0; cfg_ch = 2'd1;
    wait_tick(1, "t2_old_wrap");
    #1;
    chk("t2_ready_ch1_after_wrap", 32'(cfg_ready), 32'd1);
    for (int k = 1; k <= 5; k++) begin
      step();
      chk("t2_slw5", 32'(slw_clk[1]), 32'(k >= 2 && k <= 4));
      chk("t2_tick5", 32'(tick[1]), 32'(k == 5));
    end

    // 3: rejected writes
    cfg_ch = 2'd0; cfg_div = 8'd0; cfg_valid = 1;
    step(); cfg_valid = 0;
    chk("t3_err_div0", 32'(cfg_err), 32'd1);
    step();
    chk("t3_err_clear", 32'(cfg_err), 32'd0);
    cfg_ch = 2'd3; cfg_div = 8'd5; cfg_valid = 1;
    step(); cfg_valid = 0;
    chk("t3_err_ch", 32'(cfg_err), 32'd1);
    step();
    chk("t3_err_clear2", 32'(cfg_err), 32'd0);

    // 4: D=1 then disable
    write(0, 1);
    wait_tick(0, "t4_apply");
    for (int k = 0; k < 3; k++) begin
      step();
      chk("t4_tick1", 32'(tick[0]), 32'd1);
      chk("t4_slw1", 32'(slw_clk[0]), 32'd1);
    end
    en = 3'b110;
    step();
    chk("t4_tick_off", 32'(tick[0]), 32'd0);
    chk("t4_slw_off", 32'(slw_clk[0]), 32'd0);

    // 5: D=3 / D=7 then sync_clr
    write(0, 3);
    write(1, 7);
    en = 3'b111;
    step(12);
    sync_clr = 1;
    step();
    sync_clr = 0;
    chk("t5_clr_tick", 32'(tick), 32'd0);
    chk("t5_clr_slw", 32'(slw_clk), 32'd0);
    for (int k = 1; k <= 7; k++) begin
      step();
      chk("t5_tick_ch0", 32'(tick[0]), 32'(k % 3 == 0));
      chk("t5_tick_ch1", 32'(tick[1]), 32'(k == 7));
    end

    // 6: reset mid-period with a pending write on ch2
    write(2, 9);
    step(2);
    Rst_n = 0; #1;
    chk("t6_rst_tick", 32'(tick), 32'd0);
    chk("t6_rst_slw", 32'(slw_clk), 32'd0);
    cfg_ch = 2'd2; #1;
    chk("t6_rst_ready", 32'(cfg_ready), 32'd1);
    step();
    Rst_n = 1; en = 3'b100;
    for (int k = 1; k <= 8; k++) begin
      step();
      chk("t6_def_tick", 32'(tick[2]), 32'(k % 4 == 0));
    end

    step(2);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
